// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the ASCON message-data buffer: the writeback state
// encoding and the memory-region geometry constants.
// ---------------------------------------------------------------------------
package ascon_pkg;

  // Word index at which the buffer region starts in the Wishbone map.
  localparam int MEM_BASE_WORD = 18;
  // Number of 32-bit words held by the buffer.
  localparam int DEPTH         = 32;
  // Words per 64-bit core block.
  localparam int BLOCK_WORDS   = 2;

  // Writeback FSM: a returned cipher block is written as two 32-bit halves.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB_LO = 2'd1,
    WB_HI = 2'd2
  } wb_state_e;

endpackage

// File: rtl/ascon_buf_mem.sv
// ---------------------------------------------------------------------------
// ascon_buf_mem
// DEPTH x 32-bit register array with one write port and two combinational
// read ports: a single-word port for Wishbone reads and a paired port that
// returns an aligned 64-bit block {mem[2k+1], mem[2k]}.
//
// Ports:
//   wb_clk_i   in   clock
//   wb_rst_i   in   asynchronous active-high reset, clears every word
//   we         in   write enable
//   waddr      in   write word address
//   wdata      in   write data
//   rd_addr    in   Wishbone read word address
//   rd_data    out  mem[rd_addr]
//   pair_idx   in   block index k (word address 2k)
//   pair_data  out  {mem[2k+1], mem[2k]}
// ---------------------------------------------------------------------------
module ascon_buf_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [AW-2:0] pair_idx,
  output logic [63:0]   pair_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array is reset word-by-word because the buffer must read back
  // as all-zero after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are combinational, so a read and a write to the same word in the
  // same cycle return the pre-write value.
  assign rd_data   = mem[rd_addr];
  assign pair_data = {mem[{pair_idx, 1'b1}], mem[{pair_idx, 1'b0}]};

endmodule

// File: rtl/ascon_block_buffer.sv
// ---------------------------------------------------------------------------
// ascon_block_buffer
// Message-data buffer between the Wishbone register slave and the ASCON
// core. Holds associated data and plain/cipher text, streams 64-bit blocks
// to the core on request and writes returned cipher blocks back in place.
// The Wishbone ack/data produced here are ORed with the register-slave
// outputs at the top level.
//
// Ports:
//   wb_clk_i       in   clock
//   wb_rst_i       in   asynchronous active-high reset
//   mem_req        in   cyc&stb qualified to the buffer region
//   mem_we         in   active-low write enable (0 = write, 1 = read)
//   wb_addr        in   word address within the buffer
//   datain_wb      in   byte-masked write data
//   mem_ack_o      out  Wishbone ack for the buffer region
//   mem_dat_o      out  Wishbone read data, zero when not acking
//   start          in   operation start pulse, rewinds both pointers
//   block_request  in   core asks for the next 64-bit block
//   block_o        out  {mem[p+1], mem[p]}, held until the next fetch
//   block_valid    out  one-cycle strobe, block_o freshly loaded
//   CTblock        in   cipher block from the core
//   CTv            in   CTblock valid strobe
//   wb_busy        out  writeback in progress
//   err_o          out  sticky: CTv arrived while a writeback was busy
// ---------------------------------------------------------------------------
module ascon_block_buffer #(
  parameter int DEPTH = ascon_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   datain_wb,
  output logic          mem_ack_o,
  output logic [31:0]   mem_dat_o,
  input  logic          start,
  input  logic          block_request,
  output logic [63:0]   block_o,
  output logic          block_valid,
  input  logic [63:0]   CTblock,
  input  logic          CTv,
  output logic          wb_busy,
  output logic          err_o
);

  import ascon_pkg::*;

  localparam logic [AW-1:0] PTR_STEP = AW'(BLOCK_WORDS);

  wb_state_e     state;
  logic [63:0]   hold;
  logic [AW-1:0] ct_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_base;
  logic          req_q;

  logic          accept;
  logic          mem_wr_en;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rd_data;
  logic [63:0]   mem_pair_data;

  // A held stb is accepted only once: the ack cycle itself blocks a re-accept.
  assign accept = mem_req && (state == IDLE) && !mem_ack_o;

  // A start in the same cycle as a pending fetch serves block 0.
  assign rd_base = start ? '0 : rd_ptr;

  // Writeback owns the write port outside IDLE; Wishbone writes are only
  // accepted in IDLE, so the two never collide.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_waddr = wb_addr;
    mem_wdata = datain_wb;
    case (state)
      WB_LO: begin
        mem_wr_en = 1'b1;
        mem_waddr = ct_ptr;
        mem_wdata = hold[31:0];
      end
      WB_HI: begin
        mem_wr_en = 1'b1;
        mem_waddr = {ct_ptr[AW-1:1], 1'b1};
        mem_wdata = hold[63:32];
      end
      default: begin
        mem_wr_en = accept && !mem_we;
      end
    endcase
  end

  ascon_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .we        (mem_wr_en),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .rd_addr   (wb_addr),
    .rd_data   (mem_rd_data),
    .pair_idx  (rd_base[AW-1:1]),
    .pair_data (mem_pair_data)
  );

  // Block fetch: the request is registered first, the block is loaded on
  // the following edge from the (possibly rewound) read pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_q       <= 1'b0;
      rd_ptr      <= '0;
      block_o     <= '0;
      block_valid <= 1'b0;
    end else begin
      req_q       <= block_request;
      block_valid <= req_q;
      if (req_q) begin
        block_o <= mem_pair_data;
        rd_ptr  <= rd_base + PTR_STEP;
      end else if (start) begin
        rd_ptr <= '0;
      end
    end
  end

  // Writeback FSM with registered busy/error outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      hold    <= '0;
      ct_ptr  <= '0;
      wb_busy <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CTv) begin
            hold    <= CTblock;
            state   <= WB_LO;
            wb_busy <= 1'b1;
          end
        end
        WB_LO: begin
          state <= WB_HI;
        end
        WB_HI: begin
          state   <= IDLE;
          wb_busy <= 1'b0;
          ct_ptr  <= ct_ptr + PTR_STEP;
        end
        default: begin
          state   <= IDLE;
          wb_busy <= 1'b0;
        end
      endcase
      if (start) begin
        ct_ptr <= '0;
      end
      // A CTv dropped during a busy writeback outranks a same-cycle start.
      err_o <= (err_o && !start) || (CTv && (state != IDLE));
    end
  end

  // Wishbone response: single-cycle ack, read data only during the ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mem_ack_o <= 1'b0;
      mem_dat_o <= '0;
    end else begin
      mem_ack_o <= accept;
      mem_dat_o <= (accept && mem_we) ? mem_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_ascon_block_buffer.sv
// ---------------------------------------------------------------------------
// tb_ascon_block_buffer
// Directed bench for ascon_block_buffer. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ascon_block_buffer;

  import ascon_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        mem_req;
  logic        mem_we;
  logic [4:0]  wb_addr;
  logic [31:0] datain_wb;
  logic        mem_ack_o;
  logic [31:0] mem_dat_o;
  logic        start;
  logic        block_request;
  logic [63:0] block_o;
  logic        block_valid;
  logic [63:0] CTblock;
  logic        CTv;
  logic        wb_busy;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] BLK0 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] BLK1 = 64'h33333333_44444444;

  ascon_block_buffer dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .wb_addr       (wb_addr),
    .datain_wb     (datain_wb),
    .mem_ack_o     (mem_ack_o),
    .mem_dat_o     (mem_dat_o),
    .start         (start),
    .block_request (block_request),
    .block_o       (block_o),
    .block_valid   (block_valid),
    .CTblock       (CTblock),
    .CTv           (CTv),
    .wb_busy       (wb_busy),
    .err_o         (err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One Wishbone transfer with a bounded wait for the ack.
  task automatic wb_xfer(input string tag, input logic we_n, input logic [4:0] a,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    n         = 0;
    mem_req   = 1'b1;
    mem_we    = we_n;
    wb_addr   = a;
    datain_wb = d;
    step();
    while (mem_ack_o !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check({tag, "_ack"}, 64'(mem_ack_o), 64'd1);
    q       = mem_dat_o;
    mem_req = 1'b0;
    step();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] unused_q;
    wb_xfer("wb_write", 1'b0, a, d, unused_q);
  endtask

  task automatic wb_read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(tag, 1'b1, a, 32'h0, q);
    check(tag, 64'(q), 64'(exp));
  endtask

  // Request one block; the strobe comes one edge after the request is sampled.
  task automatic fetch(output logic [63:0] b);
    block_request = 1'b1;
    step();
    block_request = 1'b0;
    step();
    check("fetch_valid", 64'(block_valid), 64'd1);
    b = block_o;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b;
    logic [63:0] first_b;
    wb_rst_i      = 1'b1;
    mem_req       = 1'b0;
    mem_we        = 1'b1;
    wb_addr       = '0;
    datain_wb     = '0;
    start         = 1'b0;
    block_request = 1'b0;
    CTblock       = '0;
    CTv           = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_block_o", block_o, 64'h0);
    check("rst_outs", {58'h0, mem_ack_o, block_valid, wb_busy, err_o, 2'b0}, 64'h0);
    check("rst_dat", 64'(mem_dat_o), 64'h0);
    wb_rst_i = 1'b0;
    step();
    check("rst_rd_ptr", 64'(dut.rd_ptr), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));

    // Wishbone writes, then one fetch.
    wb_write(5'd0, 32'h11111111);
    wb_write(5'd1, 32'h22222222);
    wb_read_check("rd_w0", 5'd0, 32'h11111111);
    block_request = 1'b1;
    step();
    block_request = 1'b0;
    check("fetch_not_yet", 64'(block_valid), 64'd0);
    step();
    check("fetch_valid1", 64'(block_valid), 64'd1);
    check("fetch_data1", block_o, 64'h22222222_11111111);
    check("fetch_rd_ptr", 64'(dut.rd_ptr), 64'd2);
    step();
    check("fetch_pulse_end", 64'(block_valid), 64'd0);
    check("fetch_hold", block_o, 64'h22222222_11111111);

    // Cipher writeback into words 0/1, busy for exactly two cycles.
    CTblock = BLK0;
    CTv     = 1'b1;
    step();
    CTv = 1'b0;
    check("busy_c1", 64'(wb_busy), 64'd1);
    step();
    check("busy_c2", 64'(wb_busy), 64'd1);
    step();
    check("busy_c3", 64'(wb_busy), 64'd0);
    wb_read_check("ct_w0", 5'd0, 32'hCAFEF00D);
    wb_read_check("ct_w1", 5'd1, 32'hDEADBEEF);

    // Read issued the cycle after CTv stalls until IDLE; held stb acked once.
    CTblock = BLK1;
    CTv     = 1'b1;
    step();
    CTv     = 1'b0;
    mem_req = 1'b1;
    mem_we  = 1'b1;
    wb_addr = 5'd2;
    step();
    check("stall_lo", 64'(mem_ack_o), 64'd0);
    step();
    check("stall_hi", 64'(mem_ack_o), 64'd0);
    step();
    check("stall_ack", 64'(mem_ack_o), 64'd1);
    check("stall_dat", 64'(mem_dat_o), 64'h44444444);
    step();
    check("held_stb_no_ack", 64'(mem_ack_o), 64'd0);
    check("held_stb_dat0", 64'(mem_dat_o), 64'h0);
    mem_req = 1'b0;
    step();
    check("idle_no_ack", 64'(mem_ack_o), 64'd0);
    wb_read_check("ct_w3", 5'd3, 32'h33333333);

    // Sixteen fetches cover the buffer, the 17th wraps to block 0.
    pulse_start();
    fetch(first_b);
    check("wrap_b0", first_b, BLK0);
    fetch(b);
    check("wrap_b1", b, BLK1);
    for (int i = 2; i < 16; i++) begin
      fetch(b);
    end
    check("wrap_ptr", 64'(dut.rd_ptr), 64'd0);
    fetch(b);
    check("wrap_b16", b, BLK0);

    // Start mid-stream rewinds to block 0.
    fetch(b);
    check("mid_b1", b, BLK1);
    pulse_start();
    fetch(b);
    check("restart_b0", b, BLK0);

    // Start coincident with a request: served from word 0, pointer to 2.
    fetch(b);
    check("pre_coinc_b1", b, BLK1);
    start         = 1'b1;
    block_request = 1'b1;
    step();
    start         = 1'b0;
    block_request = 1'b0;
    step();
    check("coinc_valid", 64'(block_valid), 64'd1);
    check("coinc_b0", block_o, BLK0);
    check("coinc_ptr", 64'(dut.rd_ptr), 64'd2);
    step();

    // Back-to-back CTv: the second is dropped and flags an error.
    pulse_start();
    CTblock = 64'hAAAAAAAA_BBBBBBBB;
    CTv     = 1'b1;
    step();
    CTblock = 64'h55555555_66666666;
    step();
    CTv = 1'b0;
    check("err_set", 64'(err_o), 64'd1);
    step();
    wb_read_check("err_w0", 5'd0, 32'hBBBBBBBB);
    wb_read_check("err_w1", 5'd1, 32'hAAAAAAAA);
    wb_read_check("err_w2", 5'd2, 32'h44444444);
    check("err_sticky", 64'(err_o), 64'd1);
    pulse_start();
    check("err_clear", 64'(err_o), 64'd0);

    // Reset asserted in WB_HI clears everything immediately.
    fetch(b);
    CTblock = 64'h77777777_88888888;
    CTv     = 1'b1;
    step();
    CTv = 1'b0;
    step();
    check("pre_rst_state", 64'(dut.state), 64'(WB_HI));
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_state", 64'(dut.state), 64'(IDLE));
    check("mid_rst_outs", {60'h0, mem_ack_o, block_valid, wb_busy, err_o}, 64'h0);
    check("mid_rst_block", block_o, 64'h0);
    check("mid_rst_rd_ptr", 64'(dut.rd_ptr), 64'd0);
    step();
    wb_rst_i = 1'b0;
    step();
    wb_read_check("mid_rst_w0", 5'd0, 32'h0);
    wb_read_check("mid_rst_w3", 5'd3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
